// File: rtl/spi_reg_target_if.sv
// SPI serial lines between a master and spi_reg_target.
`timescale 1ns/1ps
interface spi_reg_target_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_reg_target.sv
// Mode-0 SPI target oversampled on clk: a command byte then a data byte access four 8-bit registers.
// Build option SPI_REG_AUTOINC_EN: further bytes in one transfer advance the address instead of being ignored.
`timescale 1ns/1ps
module spi_reg_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  spi_reg_target_if.slave spi,
  input  logic [7:0]      status_in,
  output logic [7:0]      reg0_out,
  output logic [7:0]      reg1_out,
  output logic [7:0]      reg2_out,
  output logic            wr_strobe,
  output logic [1:0]      wr_addr,
  output logic            xfer_done,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, TAIL} state_t;

  // The extra top stage on sclk/cs holds the previous synchronized value for edge detection.
  logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES:0]   cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
  logic cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_in_q, shift_in_d;
  logic [7:0] shift_out_q, shift_out_d;
  logic       drive_q, drive_d;
  logic       write_q, write_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic       xfer_done_q, xfer_done_d;
  logic       miso_q, miso_d;

  logic       mosi_s;
  logic [7:0] byte_in;

  function automatic logic [7:0] rd_sel(input logic [1:0] a, input logic [7:0] r0,
                                        input logic [7:0] r1, input logic [7:0] r2,
                                        input logic [7:0] st);
    case (a)
      2'd0:    rd_sel = r0;
      2'd1:    rd_sel = r1;
      2'd2:    rd_sel = r2;
      default: rd_sel = st;
    endcase
  endfunction

  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign byte_in = {shift_in_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], spi.sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-1:0], spi.cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
    sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
    cs_rise_d   = cs_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES];
    cs_fall_d   = ~cs_sync_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES];

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    drive_d     = drive_q;
    write_d     = write_q;
    addr_d      = addr_q;
    reg0_d      = reg0_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    xfer_done_d = cs_rise_q;

    if (cs_rise_q) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      shift_in_d  = 7'd0;
      shift_out_d = 8'd0;
      drive_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_q) begin
            state_d     = CMD;
            bit_cnt_d   = 3'd0;
            shift_out_d = 8'd0;
            drive_d     = 1'b0;
          end
        end
        CMD: begin
          if (sclk_rise_q) begin
            shift_in_d = byte_in[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              write_d     = byte_in[7];
              addr_d      = byte_in[1:0];
              state_d     = DATA;
              drive_d     = 1'b0;
              shift_out_d = byte_in[7] ? 8'd0
                          : rd_sel(byte_in[1:0], reg0_q, reg1_q, reg2_q, status_in);
            end
          end
        end
        DATA: begin
          // The first fall of each byte only starts driving bit7; later falls shift.
          if (sclk_fall_q) begin
            if (drive_q) shift_out_d = {shift_out_q[6:0], 1'b0};
            else         drive_d     = 1'b1;
          end
          if (sclk_rise_q) begin
            shift_in_d = byte_in[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (write_q && addr_q != 2'd3) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                case (addr_q)
                  2'd0:    reg0_d = byte_in;
                  2'd1:    reg1_d = byte_in;
                  default: reg2_d = byte_in;
                endcase
              end
`ifdef SPI_REG_AUTOINC_EN
              addr_d  = addr_q + 2'd1;
              drive_d = 1'b0;
              if (!write_q)
                shift_out_d = rd_sel(addr_q + 2'd1, reg0_q, reg1_q, reg2_q, status_in);
`else
              state_d = TAIL;
`endif
            end
          end
        end
        default: ;
      endcase
    end

    miso_d = drive_d & shift_out_d[7] & (state_d == DATA) & ~cs_sync_d[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 7'd0;
      shift_out_q <= 8'd0;
      drive_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 2'd0;
      reg0_q      <= 8'd0;
      reg1_q      <= 8'd0;
      reg2_q      <= 8'd0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 2'd0;
      xfer_done_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      cs_rise_q   <= cs_rise_d;
      cs_fall_q   <= cs_fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      drive_q     <= drive_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      reg0_q      <= reg0_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      xfer_done_q <= xfer_done_d;
      miso_q      <= miso_d;
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = ~cs_sync_q[SYNC_STAGES-1];
  assign busy        = ~cs_sync_q[SYNC_STAGES-1];
  assign reg0_out    = reg0_q;
  assign reg1_out    = reg1_q;
  assign reg2_out    = reg2_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign xfer_done   = xfer_done_q;

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: table of SPI transactions with write/read scoreboards plus hand-built corner sequences.
`timescale 1ns/1ps
module tb_spi_reg_target;
  localparam int HALF = 4;

  typedef struct {
    string           name;
    int              nbits;
    logic [7:0]      st;
    logic [0:3][7:0] tx;
    int              rx_n;
    logic [0:2][7:0] rx;
    int              wr_n;
    logic [0:2][1:0] wa;
    logic [0:2][7:0] wd;
    logic [0:2][7:0] regs;
  } vec_t;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] status_in;
  logic [7:0] reg0_out, reg1_out, reg2_out;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic       xfer_done;
  logic       busy;

  spi_reg_target_if spi_if();

  spi_reg_target #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi       (spi_if.slave),
    .status_in (status_in),
    .reg0_out  (reg0_out),
    .reg1_out  (reg1_out),
    .reg2_out  (reg2_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .xfer_done (xfer_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              xd_cnt   = 0;
  wr_t             wr_q[$];
  logic [7:0]      rd_q[$];
  vec_t            vecs[$];
  logic [0:3][7:0] tx_buf;
  logic [0:3][7:0] rx_buf;
  logic [0:2][7:0] mdl_regs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input logic [1:0] a);
    case (a)
      2'd0:    reg_at = reg0_out;
      2'd1:    reg_at = reg1_out;
      2'd2:    reg_at = reg2_out;
      default: reg_at = 8'hxx;
    endcase
  endfunction

  always @(negedge clk) begin
    if (xfer_done) xd_cnt++;
    if (wr_strobe) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wr_strobe: got strobe at addr %0d expected none", wr_addr);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(reg_at(wr_addr)), 32'(e.data));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int bi;
      int bb;
      bi = i / 8;
      bb = 7 - (i % 8);
      spi_if.mosi = tx_buf[bi[1:0]][bb[2:0]];
      wait_clk(HALF);
      rx_buf[bi[1:0]][bb[2:0]] = spi_if.miso;
      spi_if.sclk = 1'b1;
      wait_clk(HALF);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic check_regs(input string name, input logic [0:2][7:0] exp);
    check({name, "_reg0"}, 32'(reg0_out), 32'(exp[0]));
    check({name, "_reg1"}, 32'(reg1_out), 32'(exp[1]));
    check({name, "_reg2"}, 32'(reg2_out), 32'(exp[2]));
  endtask

  task automatic apply(input vec_t v);
    int xd0;
    status_in = v.st;
    tx_buf    = v.tx;
    rx_buf    = '0;
    for (int j = 0; j < v.wr_n; j++) wr_q.push_back('{addr: v.wa[j], data: v.wd[j]});
    for (int j = 0; j < v.rx_n; j++) rd_q.push_back(v.rx[j]);
    xd0 = xd_cnt;
    spi_if.cs = 1'b0;
    wait_clk(8);
    check({v.name, "_busy"}, 32'(busy), 32'd1);
    check({v.name, "_miso_oe"}, 32'(spi_if.miso_oe), 32'd1);
    spi_bits(v.nbits);
    wait_clk(HALF);
    spi_if.cs = 1'b1;
    wait_clk(12);
    check({v.name, "_xfer_done"}, 32'(xd_cnt - xd0), 32'd1);
    check({v.name, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    check({v.name, "_rx_cmd"}, 32'(rx_buf[0]), 32'd0);
    for (int j = 0; j < v.rx_n; j++) check({v.name, "_rx"}, 32'(rx_buf[j + 1]), 32'(rd_q.pop_front()));
    check_regs(v.name, v.regs);
    check({v.name, "_busy_end"}, 32'(busy), 32'd0);
    mdl_regs = v.regs;
  endtask

  function automatic vec_t mk(input string name, input int nbits, input logic [7:0] st,
                              input logic [31:0] tx, input int rx_n, input logic [23:0] rx,
                              input int wr_n, input logic [5:0] wa, input logic [23:0] wd,
                              input logic [23:0] regs);
    vec_t v;
    v.name  = name;
    v.nbits = nbits;
    v.st    = st;
    v.tx    = tx;
    v.rx_n  = rx_n;
    v.rx    = rx;
    v.wr_n  = wr_n;
    v.wa    = wa;
    v.wd    = wd;
    v.regs  = regs;
    return v;
  endfunction

  initial begin
    int xd0;
    reset       = 1'b0;
    spi_if.cs   = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    status_in   = 8'h9E;
    mdl_regs    = '0;

    vecs.push_back(mk("wr1",   16, 8'h9E, 32'h815A0000, 0, 24'h0,      1, 6'b010000, 24'h5A0000, 24'h005A00));
    vecs.push_back(mk("wr2",   16, 8'h9E, 32'h82C30000, 0, 24'h0,      1, 6'b100000, 24'hC30000, 24'h005AC3));
    vecs.push_back(mk("rd2",   16, 8'h9E, 32'h02000000, 1, 24'hC30000, 0, 6'b0,      24'h0,      24'h005AC3));
    vecs.push_back(mk("rd3",   16, 8'h9E, 32'h03000000, 1, 24'h9E0000, 0, 6'b0,      24'h0,      24'h005AC3));
    vecs.push_back(mk("rd3b",  16, 8'h5B, 32'h03000000, 1, 24'h5B0000, 0, 6'b0,      24'h0,      24'h005AC3));
    vecs.push_back(mk("wr3",   16, 8'h9E, 32'h83110000, 0, 24'h0,      0, 6'b0,      24'h0,      24'h005AC3));
    vecs.push_back(mk("part",  13, 8'h9E, 32'h80A00000, 0, 24'h0,      0, 6'b0,      24'h0,      24'h005AC3));
    vecs.push_back(mk("wr0",   16, 8'h9E, 32'h80A50000, 0, 24'h0,      1, 6'b000000, 24'hA50000, 24'hA55AC3));
    vecs.push_back(mk("rd0",   16, 8'h9E, 32'h7C000000, 1, 24'hA50000, 0, 6'b0,      24'h0,      24'hA55AC3));
    vecs.push_back(mk("wr1b",  16, 8'h9E, 32'hFD3C0000, 0, 24'h0,      1, 6'b010000, 24'h3C0000, 24'hA53CC3));
`ifdef SPI_REG_AUTOINC_EN
    vecs.push_back(mk("ai_wr", 32, 8'h9E, 32'h82010203, 0, 24'h0,      2, 6'b100000, 24'h010300, 24'h033C01));
    vecs.push_back(mk("ai_rd", 32, 8'h9E, 32'h00000000, 3, 24'h033C01, 0, 6'b0,      24'h0,      24'h033C01));
`else
    vecs.push_back(mk("extra", 24, 8'h9E, 32'h80112200, 0, 24'h0,      1, 6'b000000, 24'h110000, 24'h113CC3));
    vecs.push_back(mk("rd_ex", 24, 8'h9E, 32'h02000000, 2, 24'hC30000, 0, 6'b0,      24'h0,      24'h113CC3));
`endif

    wait_clk(3);
    check_regs("rst", 24'h000000);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_xfer_done", 32'(xfer_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(spi_if.miso), 32'd0);
    check("rst_miso_oe", 32'(spi_if.miso_oe), 32'd0);
    reset = 1'b1;
    wait_clk(5);

    foreach (vecs[k]) apply(vecs[k]);

    // cs and the 16th sclk rise arrive together: the byte must not commit
    xd0       = xd_cnt;
    tx_buf    = {8'h80, 8'h5E, 8'h00, 8'h00};
    spi_if.cs = 1'b0;
    wait_clk(8);
    spi_bits(15);
    spi_if.mosi = tx_buf[1][0];
    wait_clk(HALF);
    spi_if.sclk = 1'b1;
    spi_if.cs   = 1'b1;
    wait_clk(HALF);
    spi_if.sclk = 1'b0;
    wait_clk(12);
    check("simul_xfer_done", 32'(xd_cnt - xd0), 32'd1);
    check_regs("simul", mdl_regs);

    // reset during the 4th data bit
    xd0       = xd_cnt;
    tx_buf    = {8'h80, 8'hF0, 8'h00, 8'h00};
    spi_if.cs = 1'b0;
    wait_clk(8);
    spi_bits(11);
    spi_if.mosi = 1'b1;
    wait_clk(HALF);
    spi_if.sclk = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    check_regs("midrst", 24'h000000);
    check("midrst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_miso", 32'(spi_if.miso), 32'd0);
    check("midrst_miso_oe", 32'(spi_if.miso_oe), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'd0);
    spi_if.sclk = 1'b0;
    spi_if.cs   = 1'b1;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(8);
    check("midrst_xfer_done", 32'(xd_cnt - xd0), 32'd0);
    check_regs("after_rst", 24'h000000);

    apply(mk("post_rst", 16, 8'h9E, 32'h81770000, 0, 24'h0, 1, 6'b010000, 24'h770000, 24'h007700));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_target.md
# spi_reg_target

System-clock-domain SPI target with a small command/register interface: the responding end for the existing SPI master. It oversamples `sclk`, `cs` and `mosi` on `clk`, decodes a command byte followed by a data byte, and updates or returns one of four 8-bit registers. It sits between an SPI master's chip-select/serial lines and on-chip control logic. Everything is synchronous to one clock, with no logic clocked by `sclk`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs`, `mosi`; legal values are 2 or more.
- `clk`  input  1  system clock; the only clock in the block.
- `reset`  input  1  asynchronous, active-low reset.
- `sclk`  input  1  SPI clock from the master, asynchronous to `clk`; mode 0 (idles low).
- `cs`  input  1  chip select, active-low, asynchronous.
- `mosi`  input  1  serial data from the master, MSB first.
- `miso`  output  1  serial data to the master, MSB first.
- `miso_oe`  output  1  high while the synchronized `cs` is low; used by the top level for the MISO mux.
- `status_in`  input  8  read-only value returned at address 3.
- `reg0_out`, `reg1_out`, `reg2_out`  output  8 each  current register contents.
- `wr_strobe`  output  1  one-cycle pulse when a register is written.
- `wr_addr`  output  2  address of the write; valid while `wr_strobe` is high.
- `xfer_done`  output  1  one-cycle pulse on the synchronized `cs` rising edge.
- `busy`  output  1  equals the synchronized `cs` inverted.

## Operation
- **Protocol:** byte 0 is the command: bit7 = 1 for write, 0 for read; bits[1:0] are the address; bits[6:2] are ignored. Byte 1 is the data.
- **Input path:** `SYNC_STAGES` flops on each input, then a registered edge detector producing `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- **State machine:** IDLE -> CMD -> DATA -> TAIL.
  - IDLE: wait for `cs_fall`; clear the 3-bit bit counter; load the MISO shifter with 0x00.
  - CMD: shift `mosi` in on each `sclk_rise`. On the 8th rise, latch the command and go to DATA. For a read, load the MISO shifter with the addressed register (`status_in` at address 3).
  - DATA: on each `sclk_fall`, shift the MISO shifter left; `miso` is the shifter MSB. On each `sclk_rise`, shift `mosi` in. On the 8th rise:
    - write to address 0–2: update the register and pulse `wr_strobe` with `wr_addr` in the next cycle;
    - write to address 3: discarded, no strobe;
    - then go to TAIL.
  - TAIL: ignore further bits; `miso` = 0.
- **`cs_rise` in any state:** go to IDLE, clear the bit counter and shifters, pulse `xfer_done`. A partial data byte is never committed.
- **`miso`:** 0 whenever the synchronized `cs` is high or the state is CMD.
- **Read data timing:** read-data bit7 appears on `miso` at the `sclk_fall` after the 8th command rise. This is before the 9th rise, so it is valid for mode 0 sampling.
- **Simultaneous `cs_rise` and `sclk_rise`:** `cs_rise` wins; no shift and no commit.

## Timing
- **Reset values:** all registers 0x00; `miso` 0; `miso_oe` 0; `wr_strobe` 0; `wr_addr` 0; `xfer_done` 0; `busy` 0; state IDLE.
- **Input latency:** an input edge is seen SYNC_STAGES+1 `clk` cycles after it occurs.
- **SCLK constraint:** `sclk` high and low phases must each be at least SYNC_STAGES+2 `clk` cycles. `cs` setup to the first `sclk` rise must be at least SYNC_STAGES+2 cycles.
- **MISO latency:** `miso` changes SYNC_STAGES+2 `clk` cycles after an `sclk` fall.
- **Write latency:** `wr_strobe` and the register update occur together, 1 cycle after the detected 16th `sclk_rise`.
- **`xfer_done`:** asserted 1 cycle after `cs_rise` is detected.
- **Reset mid-transfer:** immediate return to reset values; the transfer is lost.

## Configuration
- `SPI_REG_AUTOINC_EN`
  - Defined: instead of entering TAIL, every further complete byte is handled at address+1, wrapping 3 -> 0.
    - write: each byte writes the next address (address 3 skipped, counter still advances);
    - read: the shifter reloads with the next address at each byte boundary.
  - Undefined: TAIL behaviour as described under Operation; extra bytes are ignored.

## Test plan
- Write 0x81, 0x5A, `clk`:`sclk` = 8:1 -> `reg1_out` = 0x5A; one `wr_strobe` with `wr_addr` = 1; one `xfer_done`.
- Preload `reg2_out` = 0xC3, send 0x02, 0x00 -> master receives 0xC3; no `wr_strobe`.
- `status_in` = 0x9E, read address 3 -> master receives 0x9E. Write 0x83, 0x11 -> no strobe; `reg0_out`–`reg2_out` unchanged.
- Write 0x80 then 5 data bits, then `cs` high -> `reg0_out` unchanged; `xfer_done` pulses; the next full transaction works normally.
- Assert `reset` low during bit 4 of the data byte -> all outputs at reset values; state IDLE.
- With `SPI_REG_AUTOINC_EN` defined: write 0x82, 0x01, 0x02, 0x03 -> `reg2_out` = 0x01 and `reg0_out` = 0x03 (address 3 skipped); three-byte read from address 0 returns reg0, reg1, reg2.
